// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge
// Turns each single-cycle CPU data-memory access into one transaction on an
// SRAM-like req/addr_ok/data_ok bus and holds the pipeline until the result
// has been latched. All bus-side outputs come from registers; only the
// pipeline stall request is combinational.
module dmem_sram_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_en,
  input  logic        cpu_mem_we,
  input  logic [3:0]  cpu_sel,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_stall_all,
  output logic [31:0] cpu_rdata,
  output logic        stallreq_from_mem,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access_s;

  // Transfer size from byte enables: single lane -> byte, aligned pair -> half.
  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_to_size = 2'd0;
      4'b0011, 4'b1100:                   sel_to_size = 2'd1;
      default:                            sel_to_size = 2'd2;
    endcase
  endfunction

  // kseg0/kseg1 are unmapped windows onto the bottom 512 MiB of physical space.
  function automatic logic [31:0] map_addr(input logic [31:0] vaddr);
    if (KSEG_MAP && (vaddr[31:30] == 2'b10)) begin
      map_addr = {3'b000, vaddr[28:0]};
    end else begin
      map_addr = vaddr;
    end
  endfunction

  assign access_s = cpu_mem_en && (cpu_sel != 4'b0000);

  // State register and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: capture in IDLE, hold request until accepted,
  // wait for the response, then hold the result until the pipeline moves.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        // A late data_ok left over from a reset is deliberately ignored here.
        if (access_s) begin
          state_d = ST_ADDR;
          req_d   = 1'b1;
          wr_d    = cpu_mem_we;
          size_d  = sel_to_size(cpu_sel);
          addr_d  = map_addr(cpu_addr);
          wdata_d = cpu_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        // Request stays frozen whatever the CPU does meanwhile.
        if (data_addr_ok) begin
          state_d = ST_DATA;
          req_d   = 1'b0;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (data_data_ok) begin
          state_d = ST_DONE;
          if (!wr_q) begin
            rdata_d = data_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        // Leave only when the pipeline advances, so the access is not re-issued.
        if (!cpu_stall_all) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign stallreq_from_mem = ((state_q == ST_IDLE) && access_s) ||
                             (state_q == ST_ADDR) || (state_q == ST_DATA);

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Testbench for dmem_sram_bridge: directed scenarios followed by randomized
// accesses, checked against a transaction-level reference model.
module tb_dmem_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_mem_en, cpu_mem_we, cpu_stall_all;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] cpu_rdata, data_addr, data_wdata;
  logic        stallreq_from_mem, data_req, data_wr;
  logic [1:0]  data_size;

  logic [31:0] cpu_rdata_n, data_addr_n, data_wdata_n;
  logic        stall_n, data_req_n, data_wr_n;
  logic [1:0]  data_size_n;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rdata_m;   // model of the CPU-visible load result
  int stall_cnt;

  always #5 clk = ~clk;

  dmem_sram_bridge #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_mem_en(cpu_mem_en), .cpu_mem_we(cpu_mem_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall_all(cpu_stall_all),
    .cpu_rdata(cpu_rdata), .stallreq_from_mem(stallreq_from_mem),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  dmem_sram_bridge #(.KSEG_MAP(1'b0)) dut_nomap (
    .clk(clk), .rst(rst),
    .cpu_mem_en(cpu_mem_en), .cpu_mem_we(cpu_mem_we), .cpu_sel(cpu_sel),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall_all(cpu_stall_all),
    .cpu_rdata(cpu_rdata_n), .stallreq_from_mem(stall_n),
    .data_req(data_req_n), .data_wr(data_wr_n), .data_size(data_size_n),
    .data_addr(data_addr_n), .data_wdata(data_wdata_n),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: number of enabled lanes decides the size, aligned pairs are halves.
  function automatic logic [1:0] exp_size(input logic [3:0] s);
    int n;
    n = $countones(s);
    if (n == 1) return 2'd0;
    if (s == 4'b0011 || s == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // Reference: kseg0 (0x8..0x9) and kseg1 (0xA..0xB) drop their top three bits.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input bit map);
    if (map && a >= 32'h8000_0000 && a < 32'hC000_0000) return a - (a & 32'hE000_0000);
    return a;
  endfunction

  task automatic drive_idle();
    cpu_mem_en = 1'b0; cpu_mem_we = 1'b0; cpu_sel = 4'b0000;
    cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_stall_all = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
  endtask

  // One complete access with a_dly cycles before addr_ok, d_dly cycles
  // before data_ok, and `hold` extra DONE cycles with cpu_stall_all high.
  task automatic do_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wd, input int a_dly, input int d_dly,
                           input int hold, input logic [31:0] rd, input bit drop_en);
    logic [31:0] ea;
    logic [1:0]  es;
    ea = exp_addr(addr, 1'b1);
    es = exp_size(sel);
    stall_cnt = 0;
    // cycle 0: present the access in IDLE
    @(negedge clk);
    cpu_mem_en = 1'b1; cpu_mem_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = wd;
    cpu_stall_all = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    if (stallreq_from_mem === 1'b1) stall_cnt++;
    chk("cap_req", {31'd0, data_req}, 32'd0);
    // request phase
    for (int i = 0; i <= a_dly; i++) begin
      @(negedge clk);
      cpu_mem_en = drop_en ? 1'b0 : 1'($urandom_range(0, 1));
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_mem_we = 1'($urandom_range(0, 1));
      cpu_stall_all = 1'($urandom_range(0, 1));
      data_addr_ok = (i == a_dly);
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata = $urandom;
      #1;
      if (stallreq_from_mem === 1'b1) stall_cnt++;
      chk("addr_req", {31'd0, data_req}, 32'd1);
      chk("addr_addr", data_addr, ea);
      chk("addr_size", {30'd0, data_size}, {30'd0, es});
      chk("addr_wr", {31'd0, data_wr}, {31'd0, we});
      chk("addr_wdata", data_wdata, wd);
      chk("nomap_addr", data_addr_n, addr);
      chk("addr_rdata_held", cpu_rdata, rdata_m);
    end
    // response phase
    for (int j = 0; j <= d_dly; j++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = (j == d_dly);
      data_rdata = (j == d_dly) ? rd : $urandom;
      #1;
      if (stallreq_from_mem === 1'b1) stall_cnt++;
      chk("data_req_low", {31'd0, data_req}, 32'd0);
      chk("data_rdata_held", cpu_rdata, rdata_m);
    end
    if (!we) rdata_m = rd;
    // result phase: pipeline frozen by others, then released
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      cpu_mem_en = 1'b1;
      data_data_ok = 1'b0; data_rdata = $urandom;
      cpu_stall_all = (h < hold);
      #1;
      if (stallreq_from_mem === 1'b1) stall_cnt++;
      chk("done_stall", {31'd0, stallreq_from_mem}, 32'd0);
      chk("done_req", {31'd0, data_req}, 32'd0);
      chk("done_rdata", cpu_rdata, rdata_m);
    end
    chk("stall_cycles", stall_cnt, 3 + a_dly + d_dly);
    // back in IDLE: no new access, stray data_ok must be ignored
    @(negedge clk);
    drive_idle();
    data_data_ok = 1'($urandom_range(0, 1));
    #1;
    chk("idle_req", {31'd0, data_req}, 32'd0);
    chk("idle_stall", {31'd0, stallreq_from_mem}, 32'd0);
  endtask

  initial begin
    logic [3:0]  s;
    logic [31:0] a;
    drive_idle();
    rdata_m = 32'd0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    data_data_ok = 1'b1;
    #1;
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_wr", {31'd0, data_wr}, 32'd0);
    chk("rst_size", {30'd0, data_size}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_stall", {31'd0, stallreq_from_mem}, 32'd0);
    @(negedge clk);
    rst = 1'b1; data_data_ok = 1'b0;

    // lw from kseg0, first-opportunity handshake
    do_access(1'b0, 4'b1111, 32'h8000_0010, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    // sb: result must keep the previous load value
    do_access(1'b1, 4'b0100, 32'h0000_1002, 32'h00AB_0000, 0, 0, 0, 32'h1234_5678, 1'b0);
    // slow addr_ok with cpu_mem_en dropped
    do_access(1'b0, 4'b0011, 32'hA000_0040, 32'h0, 4, 1, 0, 32'h0BAD_F00D, 1'b1);
    // pipeline held by another source for 5 cycles in DONE
    do_access(1'b0, 4'b1100, 32'h0040_0008, 32'h0, 0, 0, 5, 32'hCAFE_0001, 1'b0);

    // reset while waiting for data_ok
    @(negedge clk);
    cpu_mem_en = 1'b1; cpu_mem_we = 1'b0; cpu_sel = 4'b1111; cpu_addr = 32'h0000_0100;
    @(negedge clk);
    cpu_mem_en = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    #1;
    chk("pre_rst_stall", {31'd0, stallreq_from_mem}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    rdata_m = 32'd0;
    #1;
    chk("mid_rst_req", {31'd0, data_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stallreq_from_mem}, 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("late_ok_ignored", cpu_rdata, 32'd0);
    chk("late_ok_req", {31'd0, data_req}, 32'd0);

    // enabled but no lanes selected: nothing happens
    @(negedge clk);
    cpu_mem_en = 1'b1; cpu_sel = 4'b0000; cpu_addr = 32'hA000_0004;
    #1;
    chk("sel0_stall", {31'd0, stallreq_from_mem}, 32'd0);
    @(negedge clk);
    #1;
    chk("sel0_req", {31'd0, data_req}, 32'd0);
    chk("sel0_stall2", {31'd0, stallreq_from_mem}, 32'd0);
    // no-remap instance passes kseg1 through
    do_access(1'b1, 4'b1111, 32'hA000_0004, 32'h0102_0304, 0, 0, 0, 32'h0, 1'b0);

    // randomized accesses
    for (int k = 0; k < 40; k++) begin
      s = 4'($urandom_range(1, 15));
      a = $urandom;
      case ($urandom_range(0, 2))
        0: a[31:29] = 3'b100;
        1: a[31:29] = 3'b101;
        default: a = a;
      endcase
      do_access(1'($urandom_range(0, 1)), s, a, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
